// File: rtl/byte_serializer_pkg.sv
// Shared constants, state encoding and byte-order helpers for the byte serializer.
package byte_serializer_pkg;

   localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hBC;
   localparam int         FIFO_DEPTH        = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   // Byte that leaves first for the given word and byte order.
   function automatic logic [7:0] lead_byte(input logic [31:0] word, input logic msb_first);
      return msb_first ? word[31:24] : word[7:0];
   endfunction

   // Word with its leading byte consumed, so the next byte becomes the lead byte.
   function automatic logic [31:0] shift_word(input logic [31:0] word, input logic msb_first);
      return msb_first ? {word[23:0], 8'h00} : {8'h00, word[31:8]};
   endfunction

endpackage

// File: rtl/word_fifo2.sv
// Two-entry word FIFO with occupancy count; push when full and pop when empty are ignored.
module word_fifo2
   import byte_serializer_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full,
   output logic [1:0]   occupancy
);

   logic [W-1:0] mem_q [FIFO_DEPTH];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   occ_q;
   logic         push_ok;
   logic         pop_ok;

   assign empty     = (occ_q == 2'd0);
   assign full      = (occ_q == 2'(FIFO_DEPTH));
   assign occupancy = occ_q;
   assign push_ok   = push & ~full;
   assign pop_ok    = pop & ~empty;
   assign dout      = mem_q[rd_ptr_q];

   // Storage entries carry no reset; only pointers and count define validity.
   for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (push_ok && (wr_ptr_q == 1'(gi))) begin
            mem_q[gi] <= din;
         end
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push and pop keeps the count.
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         if (push_ok) wr_ptr_q <= ~wr_ptr_q;
         if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
         occ_q <= occ_q + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

endmodule

// File: rtl/byte_serializer.sv
// Serializes 32-bit words into a byte stream, emitting a comma code when no data is pending.
module byte_serializer
   import byte_serializer_pkg::*;
#(
   parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEFAULT,
   parameter bit         MSB_FIRST = 1'b1
) (
   input  logic        clk_4f,
   input  logic        reset,
   input  logic [31:0] data_in,
   input  logic        valid_in,
   output logic        ready_in,
   output logic [7:0]  data_out,
   output logic        valid_out,
   output logic        k_out,
   output logic        err_ovf
);

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        k_q, k_d;
   logic        err_q, err_d;

   logic        fifo_push;
   logic        fifo_pop;
   logic [31:0] fifo_dout;
   logic        fifo_empty;
   logic        fifo_full;
   logic [1:0]  fifo_occ;

   assign ready_in  = (fifo_occ < 2'(FIFO_DEPTH));
   assign fifo_push = valid_in & ready_in;
   // A new word is taken whenever the shifter is free: in IDLE, or on the last byte of a word.
   assign fifo_pop  = ~fifo_empty & ((state_q == ST_IDLE) || (cnt_q == 2'd3));

   word_fifo2 #(.W(32)) u_fifo (
      .clk       (clk_4f),
      .srst      (reset),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .din       (data_in),
      .dout      (fifo_dout),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .occupancy (fifo_occ)
   );

   // State register plus registered datapath and outputs.
   always_ff @(posedge clk_4f) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 2'd0;
         shift_q <= 32'd0;
         data_q  <= IDLE_BYTE;
         valid_q <= 1'b0;
         k_q     <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         k_q     <= k_d;
         err_q   <= err_d;
      end
   end

   // Next-state: leave IDLE as soon as a word is buffered, fall back only after byte 3 with nothing queued.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (!fifo_empty) state_d = ST_SEND;
         ST_SEND: if ((cnt_q == 2'd3) && fifo_empty) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Next registered outputs: load a word, step through its bytes, or emit the comma code.
   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q;
      k_d     = k_q;
      err_d   = err_q | (valid_in & fifo_full);
      if (fifo_pop) begin
         data_d  = lead_byte(fifo_dout, MSB_FIRST);
         shift_d = shift_word(fifo_dout, MSB_FIRST);
         cnt_d   = 2'd0;
         valid_d = 1'b1;
         k_d     = 1'b0;
      end else if ((state_q == ST_SEND) && (cnt_q != 2'd3)) begin
         data_d  = lead_byte(shift_q, MSB_FIRST);
         shift_d = shift_word(shift_q, MSB_FIRST);
         cnt_d   = cnt_q + 2'd1;
         valid_d = 1'b1;
         k_d     = 1'b0;
      end else begin
         data_d  = IDLE_BYTE;
         cnt_d   = 2'd0;
         valid_d = 1'b0;
         k_d     = 1'b1;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign k_out     = k_q;
   assign err_ovf   = err_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer: two instances (MSB-first and LSB-first) share stimulus;
// expected bytes are queued at push time and popped by a monitor when valid_out is seen.
module tb_byte_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [31:0] data_in;

   logic        rdy0, v0, k0, e0;
   logic [7:0]  dout0;
   logic        rdy1, v1, k1, e1;
   logic [7:0]  dout1;

   logic [7:0]  q0[$];
   logic [7:0]  q1[$];
   int          n_cmp = 0;
   int          n_mis = 0;
   bit          mon_en = 1'b0;
   bit          exp_err = 1'b0;

   always #5 clk = ~clk;

   byte_serializer #(.IDLE_BYTE(8'hBC), .MSB_FIRST(1'b1)) dut_msb (
      .clk_4f(clk), .reset(rst), .data_in(data_in), .valid_in(valid_in),
      .ready_in(rdy0), .data_out(dout0), .valid_out(v0), .k_out(k0), .err_ovf(e0)
   );

   byte_serializer #(.IDLE_BYTE(8'hBC), .MSB_FIRST(1'b0)) dut_lsb (
      .clk_4f(clk), .reset(rst), .data_in(data_in), .valid_in(valid_in),
      .ready_in(rdy1), .data_out(dout1), .valid_out(v1), .k_out(k1), .err_ovf(e1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Monitor: every data byte must match the scoreboard head; otherwise the comma code must show.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("excl_msb", {31'd0, v0 & k0}, 32'd0);
         chk("excl_lsb", {31'd0, v1 & k1}, 32'd0);
         if (v0 === 1'b1) begin
            if (q0.size() == 0) chk("unexpected_byte_msb", {24'd0, dout0}, 32'hFFFF_FFFF);
            else                chk("byte_msb", {24'd0, dout0}, {24'd0, q0.pop_front()});
         end else begin
            chk("idle_msb", {23'd0, k0, dout0}, {23'd0, 1'b1, 8'hBC});
         end
         if (v1 === 1'b1) begin
            if (q1.size() == 0) chk("unexpected_byte_lsb", {24'd0, dout1}, 32'hFFFF_FFFF);
            else                chk("byte_lsb", {24'd0, dout1}, {24'd0, q1.pop_front()});
         end else begin
            chk("idle_lsb", {23'd0, k1, dout1}, {23'd0, 1'b1, 8'hBC});
         end
      end
   end

   // Present one word for one edge; exp_rdy is the bench's own view of ready_in.
   task automatic push_word(input logic [31:0] w, input bit exp_rdy);
      data_in  = w;
      valid_in = 1'b1;
      chk("ready_pre_msb", {31'd0, rdy0}, {31'd0, exp_rdy});
      chk("ready_pre_lsb", {31'd0, rdy1}, {31'd0, exp_rdy});
      if (exp_rdy) begin
         for (int i = 0; i < 4; i++) begin
            q0.push_back(w[31-8*i -: 8]);
            q1.push_back(w[8*i +: 8]);
         end
      end else begin
         exp_err = 1'b1;
      end
      @(posedge clk); #1;
      valid_in = 1'b0;
      $display("push %h ready=%0d err=%0d", w, exp_rdy, exp_err);
      chk("err_ovf_msb", {31'd0, e0}, {31'd0, exp_err});
      chk("err_ovf_lsb", {31'd0, e1}, {31'd0, exp_err});
   endtask

   task automatic drain();
      int t = 0;
      while (((q0.size() + q1.size()) != 0) && (t < 60)) begin
         @(negedge clk); #1;
         t++;
      end
      chk("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      valid_in = 1'b0;
      data_in  = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;
      chk("reset_ready", {31'd0, rdy0}, 32'd1);
      chk("reset_err",   {31'd0, e0},   32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Idle stream after reset.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         $display("idle cycle %0d ready=%0d err=%0d", i, rdy0, e0);
         chk("idle_ready", {31'd0, rdy0}, 32'd1);
         chk("idle_err",   {31'd0, e0},   32'd0);
      end

      // Single word with one-cycle latency, then comma code.
      push_word(32'h11223344, 1'b1);
      @(negedge clk);
      chk("latency_not_yet", {31'd0, v0}, 32'd0);
      @(negedge clk);
      chk("latency_byte0", {23'd0, v0, dout0}, {23'd0, 1'b1, 8'h11});
      drain();
      @(negedge clk);
      chk("post_word_k", {23'd0, k0, dout0}, {23'd0, 1'b1, 8'hBC});

      // Back-to-back words stream without a gap.
      push_word(32'hAABBCCDD, 1'b1);
      push_word(32'h01020304, 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("gapless_valid", {31'd0, v0}, 32'd1);
         chk("gapless_ready", {31'd0, rdy0}, 32'd1);
      end
      @(negedge clk);
      chk("gapless_end", {31'd0, v0}, 32'd0);
      drain();

      // Overflow: continuous valid_in until ready_in falls; refused word is dropped.
      push_word(32'hDEAD0001, 1'b1);
      push_word(32'hBEEF0002, 1'b1);
      push_word(32'h12345678, 1'b1);
      push_word(32'h99999999, 1'b0);
      chk("full_ready_a", {31'd0, rdy0}, 32'd0);
      @(posedge clk); #1;
      chk("full_ready_b", {31'd0, rdy0}, 32'd0);
      @(posedge clk); #1;
      chk("full_ready_c", {31'd0, rdy0}, 32'd1);
      drain();
      repeat (3) @(posedge clk);
      #1;
      chk("err_sticky", {31'd0, e0}, 32'd1);

      // Reset in the middle of a word aborts it; valid_in during reset is ignored.
      push_word(32'hCAFEF00D, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      q0.delete();
      q1.delete();
      exp_err  = 1'b0;
      data_in  = 32'h77777777;
      valid_in = 1'b1;
      @(posedge clk); #1;
      rst      = 1'b0;
      valid_in = 1'b0;
      $display("reset abort ready=%0d err=%0d", rdy0, e0);
      chk("abort_ready", {31'd0, rdy0}, 32'd1);
      chk("abort_err",   {31'd0, e0},   32'd0);
      repeat (6) @(posedge clk);
      #1;
      chk("abort_err_later", {31'd0, e1}, 32'd0);

      // Recovery after reset.
      push_word(32'h11223344, 1'b1);
      drain();
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
